pwm_multi: RTL and testbench
============================

# pwm_multi

Multi-channel PWM generator; parametrised successor of the single-channel `pwm` block. All channels share one period counter and have independent duty values. Host writes go to shadow registers, which are copied to the active registers on one defined period boundary, so output periods are never torn. Sits between the register/MCU strobe interface and the gate-drive / LED outputs.

## Interface
Parameters:
- `WIDTH`, 16, counter/period/duty width.
- `CHANNELS`, 4, number of PWM outputs (1..16).
- `RELOAD_LEAD`, 10, cycles between `outEventCnt` and the last cycle of the period.

Ports:
- `refClk`  in  1  reference clock, 800 kHz nominal.
- `nRst`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  run enable, synchronous level.
- `centerMode`  in  1  0 = edge-aligned, 1 = center-aligned. Sampled only at reload.
- `wrStrobe`  in  1  write strobe, asynchronous to `refClk`. Rising edge is detected.
- `wrAddr`  in  $clog2(CHANNELS+1)  0 = period; k = duty of channel k-1.
- `data`  in  WIDTH  write data.
- `outPwm`  out  CHANNELS  registered PWM outputs.
- `outEventCnt`  out  1  one-cycle pulse, `RELOAD_LEAD` cycles before reload.
- `outPeriodStart`  out  1  one-cycle pulse in the first cycle of each period.

## Operation
- **Reset:** all shadow/active registers, counter, direction and mode are 0. `outPwm`, `outEventCnt` and `outPeriodStart` are 0.
- **Write path:** `wrStrobe` is synchronised by 2 FFs plus an edge register. On the detected 0→1 edge, `data` goes into shadow[`wrAddr`]. Addresses above `CHANNELS` are ignored.
- **Edge mode:** `cnt` counts 0..periodAct, then wraps to 0. Period length is periodAct+1 cycles. The last cycle is `cnt==periodAct`.
- **Center mode:** `cnt` counts up 0..periodAct, then down periodAct-1..1, then returns to 0. Period length is 2·periodAct cycles. The last cycle is `cnt==1` while counting down. If periodAct==0, the block behaves as edge mode.
- **Reload:** in the last cycle, the shadow period, all shadow duties and `centerMode` are copied to the active registers. They take effect from `cnt==0` of the next period.
- **Compare:** `outPwm[k] <= enable && (cnt < dutyAct[k])`.
  - duty 0 → constant low.
  - duty > periodAct (edge) → constant high.
  - Center mode gives a symmetric pulse centred on `cnt==0`.
- **`outEventCnt`:** asserted when the counter is exactly `RELOAD_LEAD` cycles before the last cycle. If the period is shorter than `RELOAD_LEAD`, it is asserted at `cnt==0` instead.
- **`enable` low:** counter and direction are held at 0. Outputs and pulses are 0. Writes to shadow still work. On the first cycle with `enable` high, the active registers load from shadow and the period starts at `cnt==0`.
- **Simultaneous events:** a shadow write in the same cycle as reload goes to shadow only. Reload copies the pre-write value, and the new value applies one period later.
- **Arithmetic:** all compares are WIDTH bits unsigned; there is no overflow path. Counter `+1`/`-1` never leaves the range [0, periodAct].

## Timing
- Write latency: `wrStrobe` rises before edge n → shadow is updated at edge n+3. `data`/`wrAddr` must be stable for 4 cycles after the strobe rises. Minimum strobe high and low time is 2 cycles each.
- Output latency: `outPwm` lags `cnt` by 1 cycle. `outPeriodStart` is registered and aligned with the first `outPwm` cycle of the new period.
- New duty or period values are visible on `outPwm` within at most 2 periods + 4 cycles of the write.
- Asserting `nRst` mid-period clears the outputs immediately and asynchronously. Deassertion is synchronised by the integrator.

## Structure
- `pwm_pkg` contains:
  - `ADDR_PERIOD = 0`
  - mode constants `MODE_EDGE` / `MODE_CENTER`
  - a function for the address width
- Sub-module `pwm_strobe_sync`: 2-FF synchroniser plus rising-edge detect, reusable by other strobe blocks.
- Channel compares are implemented in a generate loop inside `pwm_multi`.

## Test plan
- Reset, then write period=9 and duty0=3 in edge mode → `outPwm[0]` is high 3 / low 7 cycles, repeating every 10 cycles. `outEventCnt` fires at cnt=0 (period < 10).
- period=99, duty0=0, duty1=50, duty2=100 → ch0 constant low, ch1 50 high / 50 low, ch2 constant high. `outEventCnt` fires at cnt=89.
- Center mode, period=8, duty0=2 → 16-cycle period, `outPwm[0]` high for 3 cycles centred on cnt=0 (cnt=1,0,1).
- Write duty0 from 3 to 7 mid-period, including a write in the reload cycle → the current period stays 3. The new value appears in the next period (or the one after, for the reload-cycle write), with no glitch.
- Drop `enable` mid-period with period=20, then re-raise it → outputs go to 0 within 1 cycle. On restart, `outPeriodStart` fires and the pattern starts at cnt=0.
- Pulse `nRst` low mid-period → all outputs go to 0 asynchronously. After release, the active values are 0, so outputs stay low until a write and reload occur.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants, mode type and address-width helper for the PWM blocks
package pwm_pkg;

    localparam int ADDR_PERIOD = 0;

    typedef enum logic {
        MODE_EDGE   = 1'b0,
        MODE_CENTER = 1'b1
    } pwm_mode_e;

    function automatic int addr_width(input int channels);
        return (channels < 1) ? 1 : $clog2(channels + 1);
    endfunction

endpackage

// File: rtl/pwm_strobe_sync.sv
// pwm_strobe_sync: two-flop synchroniser for an asynchronous strobe plus registered rising-edge pulse
module pwm_strobe_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic strobe_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic rise_q;

    // synchronise the strobe and emit a one-cycle pulse on its 0->1 transition
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            meta_q <= strobe_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= sync_q & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM with a shared period counter and period-boundary shadow reload
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int CHANNELS    = 4,
    parameter int RELOAD_LEAD = 10
) (
    input  logic                            refClk,
    input  logic                            nRst,
    input  logic                            enable,
    input  logic                            centerMode,
    input  logic                            wrStrobe,
    input  logic [addr_width(CHANNELS)-1:0] wrAddr,
    input  logic [WIDTH-1:0]                data,
    output logic [CHANNELS-1:0]             outPwm,
    output logic                            outEventCnt,
    output logic                            outPeriodStart
);

    localparam int             AW   = addr_width(CHANNELS);
    localparam int             WP1  = WIDTH + 1;
    localparam logic [WIDTH:0] LEAD = WP1'(RELOAD_LEAD);

    logic                wr_rise;
    logic [WIDTH-1:0]    sh_period_q;
    logic [WIDTH-1:0]    sh_duty_q [CHANNELS];
    logic [WIDTH-1:0]    act_period_q;
    logic [WIDTH-1:0]    act_duty_q [CHANNELS];
    pwm_mode_e           mode_q;
    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic                dir_q, dir_d;
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                event_q, event_d;
    logic                start_q, start_d;
    logic                center;
    logic                last;
    logic                reload;
    logic [WIDTH:0]      span;
    logic [WIDTH:0]      rem;

    pwm_strobe_sync u_sync (
        .clk_i    (refClk),
        .rst_ni   (nRst),
        .strobe_i (wrStrobe),
        .rise_o   (wr_rise)
    );

    // host writes land in the shadow bank only; out-of-range addresses match nothing
    always_ff @(posedge refClk or negedge nRst) begin
        if (!nRst) begin
            sh_period_q <= '0;
            for (int i = 0; i < CHANNELS; i++) sh_duty_q[i] <= '0;
        end else if (wr_rise) begin
            if (wrAddr == AW'(ADDR_PERIOD)) sh_period_q <= data;
            for (int i = 0; i < CHANNELS; i++)
                if (wrAddr == AW'(i + 1)) sh_duty_q[i] <= data;
        end
    end

    // center mode with a zero period degenerates to edge mode
    assign center = (mode_q == MODE_CENTER) && (act_period_q != '0);
    assign last   = center ? (cnt_q == WIDTH'(1)) && (dir_q || act_period_q == WIDTH'(1))
                           : (cnt_q >= act_period_q);
    // while disabled the active bank tracks the shadow so a restart uses fresh values
    assign reload = !enable || last;

    // copy shadow to active on the period boundary so a running period is never torn
    always_ff @(posedge refClk or negedge nRst) begin
        if (!nRst) begin
            act_period_q <= '0;
            mode_q       <= MODE_EDGE;
            for (int i = 0; i < CHANNELS; i++) act_duty_q[i] <= '0;
        end else if (reload) begin
            act_period_q <= sh_period_q;
            mode_q       <= pwm_mode_e'(centerMode);
            act_duty_q   <= sh_duty_q;
        end
    end

    // counter walks up (and in center mode back down), restarting at 0 after the last cycle
    always_comb begin
        cnt_d = cnt_q + WIDTH'(1);
        dir_d = dir_q;
        if (reload) begin
            cnt_d = '0;
            dir_d = 1'b0;
        end else if (center && dir_q) begin
            cnt_d = cnt_q - WIDTH'(1);
        end else if (center && cnt_q >= act_period_q) begin
            cnt_d = act_period_q - WIDTH'(1);
            dir_d = 1'b1;
        end
    end

    // counter and direction state
    always_ff @(posedge refClk or negedge nRst) begin
        if (!nRst) begin
            cnt_q <= '0;
            dir_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            dir_q <= dir_d;
        end
    end

    // span is the index of the last cycle, rem the cycles still to go until it
    assign span = center ? {act_period_q, 1'b0} - WP1'(1) : {1'b0, act_period_q};
    assign rem  = !center ? {1'b0, act_period_q} - {1'b0, cnt_q}
                : dir_q   ? {1'b0, cnt_q} - WP1'(1)
                :           span - {1'b0, cnt_q};

    assign event_d = enable && ((span < LEAD) ? (cnt_q == '0) : (rem == LEAD));
    assign start_d = enable && (cnt_q == '0);

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        assign pwm_d[k] = enable && (cnt_q < act_duty_q[k]);
    end

    // register all outputs so pulses line up with the matching outPwm cycle
    always_ff @(posedge refClk or negedge nRst) begin
        if (!nRst) begin
            pwm_q   <= '0;
            event_q <= 1'b0;
            start_q <= 1'b0;
        end else begin
            pwm_q   <= pwm_d;
            event_q <= event_d;
            start_q <= start_d;
        end
    end

    assign outPwm         = pwm_q;
    assign outEventCnt    = event_q;
    assign outPeriodStart = start_q;

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed stimulus with a per-period scoreboard for pwm_multi
module tb_pwm_multi;

    logic        refClk;
    logic        nRst;
    logic        enable;
    logic        centerMode;
    logic        wrStrobe;
    logic [2:0]  wrAddr;
    logic [15:0] data;
    logic [3:0]  outPwm;
    logic        outEventCnt;
    logic        outPeriodStart;

    pwm_multi dut (
        .refClk         (refClk),
        .nRst           (nRst),
        .enable         (enable),
        .centerMode     (centerMode),
        .wrStrobe       (wrStrobe),
        .wrAddr         (wrAddr),
        .data           (data),
        .outPwm         (outPwm),
        .outEventCnt    (outEventCnt),
        .outPeriodStart (outPeriodStart)
    );

    typedef struct packed {
        logic [15:0]      len;
        logic [15:0]      ev;
        logic [3:0][15:0] hi;
        logic [3:0][15:0] fl;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit   have_exp = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    initial begin
        refClk = 0;
        forever #5 refClk = ~refClk;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    task automatic push(input int len, input int ev,
                        input int h0, input int h1, input int h2, input int h3,
                        input int f0, input int f1, input int f2, input int f3);
        exp_t e;
        e.len = 16'(len);
        e.ev  = 16'(ev);
        e.hi  = {16'(h3), 16'(h2), 16'(h1), 16'(h0)};
        e.fl  = {16'(f3), 16'(f2), 16'(f1), 16'(f0)};
        q.push_back(e);
    endtask

    task automatic wr(input int a, input int d);
        wrAddr   = 3'(a);
        data     = 16'(d);
        wrStrobe = 1;
        repeat (2) @(posedge refClk);
        #1 wrStrobe = 0;
        repeat (2) @(posedge refClk);
        #1;
    endtask

    task automatic settle();
        repeat (2) @(posedge refClk);
        #1;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        do begin
            @(posedge refClk);
            #1 n++;
        end while (!outPeriodStart && n < 300);
        chk("period start seen", int'(outPeriodStart), 1);
    endtask

    // monitor: binds a queued expectation to each period as it starts, checks it when the next one starts
    initial begin
        int m_len, m_ev, m_evn;
        int m_hi [4];
        int m_fl [4];
        m_len = 0;
        m_ev  = -1;
        m_evn = 0;
        for (int c = 0; c < 4; c++) begin
            m_hi[c] = 0;
            m_fl[c] = -1;
        end
        forever begin
            @(negedge refClk);
            if (outPeriodStart) begin
                if (have_exp) begin
                    chk("period length", m_len, int'(cur.len));
                    chk("event index", m_ev, int'(cur.ev));
                    chk("event count", m_evn, 1);
                    for (int c = 0; c < 4; c++) begin
                        chk($sformatf("high cycles ch%0d", c), m_hi[c], int'(cur.hi[c]));
                        chk($sformatf("first low ch%0d", c), (m_fl[c] < 0) ? m_len : m_fl[c], int'(cur.fl[c]));
                    end
                    have_exp = 0;
                end
                if (q.size() > 0) begin
                    cur = q.pop_front();
                    have_exp = 1;
                end
                m_len = 0;
                m_ev  = -1;
                m_evn = 0;
                for (int c = 0; c < 4; c++) begin
                    m_hi[c] = 0;
                    m_fl[c] = -1;
                end
            end
            if (have_exp) begin
                if (outEventCnt) begin
                    if (m_ev < 0) m_ev = m_len;
                    m_evn++;
                end
                for (int c = 0; c < 4; c++) begin
                    if (outPwm[c]) m_hi[c]++;
                    else if (m_fl[c] < 0) m_fl[c] = m_len;
                end
                m_len++;
            end
        end
    end

    initial begin
        int n;
        logic [3:0] acc;
        nRst = 0;
        enable = 0;
        centerMode = 0;
        wrStrobe = 0;
        wrAddr = 0;
        data = 0;
        repeat (3) @(posedge refClk);
        #1;
        chk("reset outPwm", int'(outPwm), 0);
        chk("reset outEventCnt", int'(outEventCnt), 0);
        chk("reset outPeriodStart", int'(outPeriodStart), 0);
        nRst = 1;

        // edge mode, period 9, duty0 3
        wr(0, 9);
        wr(1, 3);
        settle();
        chk("disabled outPwm", int'(outPwm), 0);
        enable = 1;
        wait_start(n);
        chk("first start latency", n, 1);
        push(10, 0, 3, 0, 0, 0, 3, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            wait_start(n);
            push(10, 0, 3, 0, 0, 0, 3, 0, 0, 0);
        end

        // period 99 with duties 0 / 50 / 100; writes above CHANNELS must be ignored
        wr(0, 99);
        wr(1, 0);
        wr(5, 7);
        wr(2, 50);
        wr(7, 1);
        wr(3, 100);
        settle();
        for (int i = 0; i < 2; i++) begin
            wait_start(n);
            push(100, 89, 0, 50, 100, 0, 0, 50, 100, 0);
        end

        // center mode, period 8, duty0 2
        centerMode = 1;
        wr(0, 8);
        wr(1, 2);
        settle();
        for (int i = 0; i < 2; i++) begin
            wait_start(n);
            push(16, 5, 3, 16, 16, 0, 2, 16, 16, 0);
        end

        // duty0 3 -> 7 mid-period, then 7 -> 3 landing in the reload cycle
        centerMode = 0;
        wr(0, 9);
        wr(1, 3);
        settle();
        wait_start(n);
        push(10, 0, 3, 10, 10, 0, 3, 10, 10, 0);
        wr(1, 7);
        wait_start(n);
        push(10, 0, 7, 10, 10, 0, 7, 10, 10, 0);
        wait_start(n);
        push(10, 0, 7, 10, 10, 0, 7, 10, 10, 0);
        repeat (5) @(posedge refClk);
        #1;
        wr(1, 3);
        wait_start(n);
        push(10, 0, 7, 10, 10, 0, 7, 10, 10, 0);
        wait_start(n);
        push(10, 0, 3, 10, 10, 0, 3, 10, 10, 0);

        // period 20, enable dropped mid-period and raised again
        wr(0, 20);
        settle();
        wait_start(n);
        push(21, 10, 3, 21, 21, 0, 3, 21, 21, 0);
        wait_start(n);
        repeat (5) @(posedge refClk);
        #1 enable = 0;
        @(posedge refClk);
        #1;
        chk("disable outPwm", int'(outPwm), 0);
        chk("disable outEventCnt", int'(outEventCnt), 0);
        chk("disable outPeriodStart", int'(outPeriodStart), 0);
        repeat (4) @(posedge refClk);
        #1;
        chk("disabled hold outPwm", int'(outPwm), 0);
        enable = 1;
        wait_start(n);
        chk("restart latency", n, 1);
        push(21, 10, 3, 21, 21, 0, 3, 21, 21, 0);
        wait_start(n);

        // asynchronous reset mid-period
        repeat (5) @(posedge refClk);
        #1;
        chk("pre-reset outPwm", int'(outPwm), 6);
        #2 nRst = 0;
        #1;
        chk("async reset outPwm", int'(outPwm), 0);
        chk("async reset outEventCnt", int'(outEventCnt), 0);
        chk("async reset outPeriodStart", int'(outPeriodStart), 0);
        repeat (3) @(posedge refClk);
        #1 nRst = 1;
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge refClk);
            #1 acc |= outPwm;
        end
        chk("post-reset outPwm stays low", int'(acc), 0);
        wr(0, 4);
        wr(1, 2);
        settle();
        wait_start(n);
        push(5, 0, 2, 0, 0, 0, 2, 0, 0, 0);

        for (int i = 0; i < 400 && (q.size() > 0 || have_exp); i++) @(posedge refClk);
        chk("scoreboard drained", q.size() + int'(have_exp), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
